truth_table_checker: RTL and testbench

Sequential response checker for small combinational blocks under test. It receives sampled input vectors {a,b,c} and the DUT output y, and compares each y against a parameterised 8-entry expected truth table. It tracks input-space coverage, mismatch counts and a liveness timeout, then reports pass/fail, so exhaustive sweeps of 3-input circuits are self-checking in hardware rather than by reading printed output.

---
 rtl/truth_table_checker.sv | 164 ++++++++++++++++
 tb/tb_truth_table_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sequential response checker: compares sampled {a,b,c} -> y against EXP_TABLE, tracks coverage,
// saturating sample/error counts and an idle timeout. Optional TT_CHECK_FIRST_FAIL_EN adds first-fail capture.
module truth_table_checker #(
  parameter logic [7:0] EXP_TABLE   = 8'b1110_1000,
  parameter int         CNT_W       = 8,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [7:0]       cov_mask,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef TT_CHECK_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [15:0]      IDLE_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [7:0]       r_cov_mask;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [15:0]      r_idle_cnt;

  logic [2:0]       w_idx;
  logic             w_exp;
  logic             w_mismatch;
  logic [7:0]       w_cov_next;
  logic [CNT_W-1:0] w_sample_next;
  logic [CNT_W-1:0] w_err_next;
  logic             w_complete;

  assign w_idx = {a, b, c};
  assign w_exp = EXP_TABLE[w_idx];

  // NOTE: default first so every path assigns w_mismatch (no latch); an X/Z on y makes the
  // equality unknown, the if is not taken, and the sample is counted as a mismatch.
  always_comb begin
    w_mismatch = 1'b1;
    if (y == w_exp) w_mismatch = 1'b0;
  end

  assign w_cov_next    = r_cov_mask | (8'b1 << w_idx);
  assign w_sample_next = (r_sample_cnt == CNT_MAX) ? r_sample_cnt : r_sample_cnt + CNT_ONE;
  assign w_err_next    = (w_mismatch && (r_err_cnt != CNT_MAX)) ? r_err_cnt + CNT_ONE : r_err_cnt;
  assign w_complete    = (w_cov_next == 8'hFF);

`ifdef TT_CHECK_FIRST_FAIL_EN
  logic       r_ff_valid;
  logic [3:0] r_ff_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ff_valid <= 1'b0;
      r_ff_vec   <= 4'h0;
    end else if (start) begin
      r_ff_valid <= 1'b0;
      r_ff_vec   <= 4'h0;
    end else if (r_state == ST_RUN && sample_valid && w_mismatch && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_vec   <= {w_idx, y};
    end
  end

  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cov_mask   <= 8'h00;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_idle_cnt   <= 16'h0000;
    end else if (start) begin
      // Start wins over a coincident sample and restarts from any state.
      r_state      <= ST_RUN;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cov_mask   <= 8'h00;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_idle_cnt   <= 16'h0000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (sample_valid) begin
            r_cov_mask   <= w_cov_next;
            r_sample_cnt <= w_sample_next;
            r_err_cnt    <= w_err_next;
            r_idle_cnt   <= 16'h0000;
            if (w_complete) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_fail  <= (w_err_next != '0);
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'h0001;
            if (r_idle_cnt == IDLE_LAST) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_fail    <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything; samples are ignored.
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign cov_mask   = r_cov_mask;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: two instances (default and CNT_W=2/short timeout)
// checked every cycle against a history-based reference model, plus directed literal checks.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, sample_valid, a, b, c, y;

  logic       busy0, done0, pass0, fail0, to0;
  logic [7:0] cov0, scnt0, ecnt0;
  logic       busy1, done1, pass1, fail1, to1;
  logic [7:0] cov1;
  logic [1:0] scnt1, ecnt1;
`ifdef TT_CHECK_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [3:0] ffvec0, ffvec1;
`endif

  truth_table_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout(to0),
    .cov_mask(cov0), .sample_cnt(scnt0), .err_cnt(ecnt0)
`ifdef TT_CHECK_FIRST_FAIL_EN
    , .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
`endif
  );

  truth_table_checker #(.CNT_W(2), .TIMEOUT_CYC(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout(to1),
    .cov_mask(cov1), .sample_cnt(scnt1), .err_cnt(ecnt1)
`ifdef TT_CHECK_FIRST_FAIL_EN
    , .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic maj(input logic [2:0] i);
    return $countones(i) >= 2;
  endfunction

  // Reference model: a run is described by what it has seen (sample and error totals,
  // set of covered vectors, idle streak); saturation is applied only when reporting.
  int         m_mode  [2];  // 0 idle, 1 run, 2 done
  int         m_idle  [2];
  int         m_ns    [2];
  int         m_ne    [2];
  bit         m_to    [2];
  logic [7:0] m_cov   [2];
  bit         m_ffv   [2];
  logic [3:0] m_ffvec [2];
  int         m_tmo   [2] = '{255, 12};
  int         m_cmax  [2] = '{255, 3};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || start) begin
        m_mode[k] = rst_n ? 1 : 0;
        m_idle[k] = 0; m_ns[k] = 0; m_ne[k] = 0; m_to[k] = 0;
        m_cov[k] = 8'h00; m_ffv[k] = 0; m_ffvec[k] = 4'h0;
      end else if (m_mode[k] == 1) begin
        if (sample_valid) begin
          m_ns[k]++;
          if (y !== maj({a, b, c})) begin
            m_ne[k]++;
            if (!m_ffv[k]) begin m_ffv[k] = 1; m_ffvec[k] = {a, b, c, y}; end
          end
          m_cov[k][{a, b, c}] = 1'b1;
          m_idle[k] = 0;
          if (m_cov[k] == 8'hFF) m_mode[k] = 2;
        end else begin
          m_idle[k]++;
          if (m_idle[k] == m_tmo[k]) begin m_mode[k] = 2; m_to[k] = 1; end
        end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic compare_inst(input int k, input string p, input logic bz, dn, ps, fl, tmo,
                              input logic [7:0] cov, input logic [31:0] sc, ec);
    bit exp_pass;
    exp_pass = (m_mode[k] == 2) && (m_ne[k] == 0) && (m_cov[k] == 8'hFF) && !m_to[k];
    check({p, "busy"}, 32'(bz), 32'(m_mode[k] == 1));
    check({p, "done"}, 32'(dn), 32'(m_mode[k] == 2));
    check({p, "pass"}, 32'(ps), 32'(exp_pass));
    check({p, "fail"}, 32'(fl), 32'((m_mode[k] == 2) && !exp_pass));
    check({p, "timeout"}, 32'(tmo), 32'(m_to[k]));
    check({p, "cov_mask"}, 32'(cov), 32'(m_cov[k]));
    check({p, "sample_cnt"}, sc, 32'(sat(m_ns[k], m_cmax[k])));
    check({p, "err_cnt"}, ec, 32'(sat(m_ne[k], m_cmax[k])));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      compare_inst(0, "u0.", busy0, done0, pass0, fail0, to0, cov0, 32'(scnt0), 32'(ecnt0));
      compare_inst(1, "u1.", busy1, done1, pass1, fail1, to1, cov1, 32'(scnt1), 32'(ecnt1));
`ifdef TT_CHECK_FIRST_FAIL_EN
      check("u0.ff_valid", 32'(ffv0), 32'(m_ffv[0]));
      check("u0.ff_vec", 32'(ffvec0), 32'(m_ffvec[0]));
      check("u1.ff_valid", 32'(ffv1), 32'(m_ffv[1]));
      check("u1.ff_vec", 32'(ffvec1), 32'(m_ffvec[1]));
`endif
    end
  end

  // Apply inputs for one rising edge; returns 2 ns after that edge.
  task automatic cyc(input logic rn, st, sv, input logic [2:0] idx, input logic yy);
    rst_n = rn; start = st; sample_valid = sv; {a, b, c} = idx; y = yy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(1, 0, 0, 3'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(busy0), 0);
    check({tag, ".done"}, 32'(done0), 0);
    check({tag, ".pass"}, 32'(pass0), 0);
    check({tag, ".fail"}, 32'(fail0), 0);
    check({tag, ".timeout"}, 32'(to0), 0);
    check({tag, ".cov"}, 32'(cov0), 0);
    check({tag, ".scnt"}, 32'(scnt0), 0);
    check({tag, ".ecnt"}, 32'(ecnt0), 0);
`ifdef TT_CHECK_FIRST_FAIL_EN
    check({tag, ".ffv"}, 32'(ffv0), 0);
    check({tag, ".ffvec"}, 32'(ffvec0), 0);
`endif
  endtask

  initial begin
    int k;
    int silence;
    logic [2:0] idx;
    rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; a = 0; b = 0; c = 0; y = 0;
    cyc(0, 0, 0, 3'd0, 1'b0);
    cmp_en = 1'b1;
    cyc(0, 0, 1, 3'd7, 1'b1);
    check_all_zero("reset");

    // Full correct sweep, one sample per 10 cycles.
    cyc(1, 1, 0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1, 3'(i), maj(3'(i)));
      if (i == 6) check("sweep.done_before_last", 32'(done0), 0);
      if (i < 7) repeat (9) idle_cyc();
    end
    check("sweep.done", 32'(done0), 1);
    check("sweep.pass", 32'(pass0), 1);
    check("sweep.cov", 32'(cov0), 32'hFF);
    check("sweep.scnt", 32'(scnt0), 8);
    check("sweep.ecnt", 32'(ecnt0), 0);
    repeat (3) cyc(1, 0, 1, 3'd2, 1'b0);
    check("sweep.hold_scnt", 32'(scnt0), 8);

    // Sweep with y inverted at idx 3.
    cyc(1, 1, 0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 3'(i), maj(3'(i)) ^ (i == 3));
    check("inv3.done", 32'(done0), 1);
    check("inv3.fail", 32'(fail0), 1);
    check("inv3.pass", 32'(pass0), 0);
    check("inv3.ecnt", 32'(ecnt0), 1);
`ifdef TT_CHECK_FIRST_FAIL_EN
    check("inv3.ffvec", 32'(ffvec0), 32'b0110);
`endif

    // Partial coverage then silence: timeout 255 cycles after the last sample.
    cyc(1, 1, 0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 3'(i), maj(3'(i)));
    k = 0;
    while (!done0 && k < 400) begin idle_cyc(); k++; end
    check("tmo.latency", 32'(k), 255);
    check("tmo.timeout", 32'(to0), 1);
    check("tmo.fail", 32'(fail0), 1);
    check("tmo.cov", 32'(cov0), 32'h7F);

    // Duplicates of idx 0 then the rest.
    cyc(1, 1, 0, 3'd0, 1'b0);
    repeat (3) cyc(1, 0, 1, 3'd0, 1'b0);
    for (int i = 1; i < 7; i++) cyc(1, 0, 1, 3'(i), maj(3'(i)));
    check("dup.not_done", 32'(done0), 0);
    cyc(1, 0, 1, 3'd7, 1'b1);
    check("dup.done", 32'(done0), 1);
    check("dup.scnt", 32'(scnt0), 10);
    check("dup.pass", 32'(pass0), 1);

    // Start with coincident sample, then reset mid-run.
    cyc(1, 1, 1, 3'd5, 1'b1);
    check("startwin.scnt", 32'(scnt0), 0);
    check("startwin.busy", 32'(busy0), 1);
    cyc(1, 0, 1, 3'd2, 1'b0);
    check("startwin.scnt2", 32'(scnt0), 1);
    cyc(0, 0, 1, 3'd4, 1'b1);
    check_all_zero("midreset");
    cyc(1, 0, 1, 3'd3, 1'b1);
    check("idle.ignore", 32'(scnt0), 0);

    // Saturation on the CNT_W=2 instance.
    cyc(1, 1, 0, 3'd0, 1'b0);
    repeat (5) cyc(1, 0, 1, 3'd0, 1'b1);
    check("sat.ecnt", 32'(ecnt1), 3);
    check("sat.scnt", 32'(scnt1), 3);
    check("sat.busy", 32'(busy1), 1);
    check("sat.ecnt_wide", 32'(ecnt0), 5);

    // Randomized traffic checked every cycle by the model.
    silence = 0;
    for (int n = 0; n < 5000; n++) begin
      int r;
      logic rn, st, sv;
      r = $urandom_range(0, 999);
      rn = (r >= 2);
      st = (r >= 2 && r < 10);
      if (silence == 0 && $urandom_range(0, 149) == 0) silence = $urandom_range(5, 300);
      if (silence > 0) begin sv = 1'b0; silence--; end
      else sv = ($urandom_range(0, 3) != 0);
      idx = 3'($urandom_range(0, 7));
      cyc(rn, st, sv, idx, maj(idx) ^ ($urandom_range(0, 7) == 0));
    end
    idle_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
